// File: rtl/cim_pkg.sv
// Shared definitions for the CIM weight array write path.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package cim_pkg;

  localparam int WORD_W        = 12;
  localparam int WORDS_PER_ROW = 16;
  localparam int NUM_BLOCKS    = 9;
  localparam int ROW_W         = WORD_W * WORDS_PER_ROW;
  localparam int SLOT_W        = $clog2(WORDS_PER_ROW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } ld_state_t;

  // One-hot block strobe; indices >= NUM_BLOCKS fall off the top and give 0.
  function automatic logic [NUM_BLOCKS-1:0] blk_onehot(input logic [3:0] blk);
    blk_onehot = NUM_BLOCKS'(1) << blk;
  endfunction

endpackage

// File: rtl/cim_row_packer.sv
// Packs accepted weight words into one row register, word k at bits [k*WORD_W +: WORD_W].
// Latency: word visible in d one cycle after acceptance; row_full flags the last word combinationally.
// Backpressure: none internally; the caller qualifies accept with its own ready.
//
// Ports:
//   clk, rstn  - clock, async active-low reset
//   accept     - a word is taken this cycle
//   word       - the weight word to store
//   d          - packed row register (held until overwritten)
//   row_full   - accept of the last slot in the row this cycle
module cim_row_packer
  import cim_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              accept,
  input  logic [WORD_W-1:0] word,
  output logic [ROW_W-1:0]  d,
  output logic              row_full
);

  logic [SLOT_W-1:0] slot;

  assign row_full = accept && (slot == SLOT_W'(WORDS_PER_ROW - 1));

  // The slot counter width matches the row size exactly, so the increment
  // after the last word wraps to 0 on its own.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot <= '0;
      d    <= '0;
    end else if (accept) begin
      d[slot*WORD_W +: WORD_W] <= word;
      slot                     <= slot + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/cim_weight_loader.sv
// Streams weight words into 192-bit rows and writes them to consecutive CIM array blocks.
// Latency: 17 cycles per block with continuous input (16 fill cycles + 1 write strobe cycle).
// Backpressure: in_ready is high only while filling; in_valid gaps simply stall the fill.
//
// Ports:
//   clk, rstn                       - clock, async active-low reset
//   start, bank_sel, blk_first,
//   blk_count                       - load request, sampled in IDLE only
//   in_valid, in_data, in_ready     - weight word handshake
//   D, WA, cima                     - array write port (D row, one-hot block strobe, bank select)
//   busy, done, err                 - status: load active, completion pulse, rejected-start pulse
module cim_weight_loader
  import cim_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  bank_sel,
  input  logic [3:0]            blk_first,
  input  logic [3:0]            blk_count,
  input  logic                  in_valid,
  input  logic [WORD_W-1:0]     in_data,
  output logic                  in_ready,
  output logic [ROW_W-1:0]      D,
  output logic [NUM_BLOCKS-1:0] WA,
  output logic                  cima,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  ld_state_t             state, state_n;
  logic [3:0]            cur_blk, cur_blk_n;
  logic [4:0]            end_blk, end_blk_n;
  logic                  cima_n, in_ready_n, busy_n, done_n, err_n;
  logic [NUM_BLOCKS-1:0] wa_n;

  logic       accept;
  logic       row_full;
  logic [4:0] req_end;
  logic       req_ok;

  assign accept = in_valid && in_ready;

  // Range check done 5 bits wide so blk_first+blk_count cannot wrap.
  assign req_end = {1'b0, blk_first} + {1'b0, blk_count};
  assign req_ok  = (blk_count != 4'd0) && (req_end <= 5'(NUM_BLOCKS));

  cim_row_packer u_packer (
    .clk      (clk),
    .rstn     (rstn),
    .accept   (accept),
    .word     (in_data),
    .d        (D),
    .row_full (row_full)
  );

  // Next-state and next-output logic. Every output is a register, so the
  // values computed here appear in the cycle the new state is entered.
  always_comb begin
    state_n    = state;
    cur_blk_n  = cur_blk;
    end_blk_n  = end_blk;
    cima_n     = cima;
    in_ready_n = 1'b0;
    wa_n       = '0;
    busy_n     = busy;
    done_n     = 1'b0;
    err_n      = 1'b0;

    unique case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          if (req_ok) begin
            cima_n     = bank_sel;
            cur_blk_n  = blk_first;
            end_blk_n  = req_end;
            state_n    = FILL;
            in_ready_n = 1'b1;
            busy_n     = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      FILL: begin
        if (row_full) begin
          wa_n    = blk_onehot(cur_blk);
          state_n = WRITE;
        end else begin
          in_ready_n = 1'b1;
        end
      end
      WRITE: begin
        cur_blk_n = cur_blk + 4'd1;
        if (({1'b0, cur_blk} + 5'd1) == end_blk) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          state_n    = FILL;
          in_ready_n = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cur_blk  <= '0;
      end_blk  <= '0;
      cima     <= 1'b0;
      in_ready <= 1'b0;
      WA       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      cur_blk  <= cur_blk_n;
      end_blk  <= end_blk_n;
      cima     <= cima_n;
      in_ready <= in_ready_n;
      WA       <= wa_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

endmodule

// File: tb/tb_cim_weight_loader.sv
// Scoreboard bench for cim_weight_loader: loads are issued with random data,
// expected row writes and done pulses are queued from a simple row/block model,
// and a negedge monitor checks every WA strobe and done pulse against the queue.
module tb_cim_weight_loader;
  import cim_pkg::*;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic                  start = 1'b0;
  logic                  bank_sel = 1'b0;
  logic [3:0]            blk_first = '0;
  logic [3:0]            blk_count = '0;
  logic                  in_valid = 1'b0;
  logic [WORD_W-1:0]     in_data = '0;
  logic                  in_ready;
  logic [ROW_W-1:0]      D;
  logic [NUM_BLOCKS-1:0] WA;
  logic                  cima;
  logic                  busy;
  logic                  done;
  logic                  err;

  cim_weight_loader dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .bank_sel  (bank_sel),
    .blk_first (blk_first),
    .blk_count (blk_count),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .D         (D),
    .WA        (WA),
    .cima      (cima),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NUM_BLOCKS-1:0] wa;
    logic [ROW_W-1:0]      d;
    logic                  cima;
    int                    exp_cyc;
  } wr_t;

  wr_t wr_q[$];
  int  done_q[$];
  int  checks = 0;
  int  errors = 0;
  int  wa_due = -1;
  wr_t e;
  int  de;

  task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: got %s expected none", name, what);
  endtask

  // Monitor: every strobe and done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (rstn) begin
      if (WA != '0) begin
        chk("wa_onehot", ROW_W'($countones(WA)), ROW_W'(1));
        chk("in_ready_in_write", ROW_W'(in_ready), ROW_W'(0));
        if (wr_q.size() == 0) begin
          fail_now("unexpected_wa", $sformatf("%0h", WA));
        end else begin
          e = wr_q.pop_front();
          chk("wa", ROW_W'(WA), ROW_W'(e.wa));
          chk("row_d", D, e.d);
          chk("cima", ROW_W'(cima), ROW_W'(e.cima));
          if (e.exp_cyc >= 0) chk("wa_cycle", ROW_W'(cyc), ROW_W'(e.exp_cyc));
          chk("wa_after_16th", ROW_W'(cyc), ROW_W'(wa_due));
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          fail_now("unexpected_done", "1");
        end else begin
          de = done_q.pop_front();
          if (de >= 0) chk("done_cycle", ROW_W'(cyc), ROW_W'(de));
          chk("busy_at_done", ROW_W'(busy), ROW_W'(1));
        end
      end
    end
  end

  // One load request. gap_pct: chance (%) of a bubble on in_valid.
  // abort_after >= 0: reset the DUT after that many accepted words.
  task automatic run_load(input logic bank, input int first, input int count, input int gap_pct,
                          input bit mid_start, input int abort_after, input bit seq_data);
    logic [WORD_W-1:0] words[$];
    logic [ROW_W-1:0]  row;
    bit                valid_req;
    bit                accept;
    bit                bad;
    int                n;
    int                idx;
    int                base;
    int                budget;

    valid_req = (count != 0) && (first + count <= NUM_BLOCKS);
    n   = valid_req ? count * WORDS_PER_ROW : 0;
    idx = 0;
    for (int i = 0; i < n; i++) words.push_back(seq_data ? WORD_W'(i) : WORD_W'($urandom));

    @(negedge clk);
    start     = 1'b1;
    bank_sel  = bank;
    blk_first = 4'(first);
    blk_count = 4'(count);
    @(negedge clk);
    start = 1'b0;
    base  = cyc;

    if (!valid_req) begin
      chk("err_pulse", ROW_W'(err), ROW_W'(1));
      chk("busy_after_bad_start", ROW_W'(busy), ROW_W'(0));
      @(negedge clk);
      chk("err_one_cycle", ROW_W'(err), ROW_W'(0));
      bad = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (in_ready || busy || err) bad = 1'b1;
      end
      chk("idle_after_bad_start", ROW_W'(bad), ROW_W'(0));
      return;
    end

    chk("busy_after_start", ROW_W'(busy), ROW_W'(1));
    chk("cima_latched", ROW_W'(cima), ROW_W'(bank));

    if (abort_after < 0) begin
      for (int b = 0; b < count; b++) begin
        wr_t w;
        row = '0;
        for (int k = 0; k < WORDS_PER_ROW; k++) row[k*WORD_W +: WORD_W] = words[b*WORDS_PER_ROW + k];
        w.wa      = NUM_BLOCKS'(1) << (first + b);
        w.d       = row;
        w.cima    = bank;
        w.exp_cyc = (gap_pct == 0) ? base + 17 * (b + 1) - 1 : -1;
        wr_q.push_back(w);
      end
      done_q.push_back((gap_pct == 0) ? base + 17 * count : -1);
    end

    budget = count * 17 * 8 + 100;
    while (budget > 0) begin
      if (abort_after >= 0 && idx == abort_after) break;
      if (idx >= n && !busy) break;
      if (mid_start) begin
        if (idx == 5) begin
          start     = 1'b1;
          bank_sel  = ~bank;
          blk_first = 4'd0;
          blk_count = 4'd1;
        end else begin
          start = 1'b0;
        end
      end
      in_valid = (idx < n) && ($urandom_range(99) >= gap_pct);
      in_data  = in_valid ? words[idx] : WORD_W'($urandom);
      accept   = in_valid && in_ready;
      if (accept && (idx % WORDS_PER_ROW) == WORDS_PER_ROW - 1) wa_due = cyc + 1;
      @(negedge clk);
      if (accept) idx++;
      budget--;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    if (budget == 0) fail_now("load_timeout", $sformatf("idx=%0d busy=%0d", idx, busy));

    if (abort_after >= 0) begin
      rstn = 1'b0;
      #1;
      chk("outputs_in_reset", ROW_W'({in_ready, WA, cima, busy, done, err}), ROW_W'(0));
      chk("d_in_reset", D, '0);
      @(negedge clk);
      rstn = 1'b1;
      return;
    end

    chk("idle_after_load", ROW_W'({in_ready, WA, busy}), ROW_W'(0));
  endtask

  initial begin
    int f;
    int c;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", ROW_W'({in_ready, WA, cima, busy, done, err}), ROW_W'(0));
    chk("reset_d", D, '0);
    rstn = 1'b1;
    @(negedge clk);

    run_load(1'b1, 0, 9, 0, 1'b0, -1, 1'b1);   // full bank, data 0..143
    run_load(1'b0, 7, 2, 0, 1'b0, -1, 1'b0);   // partial at the top of the bank
    run_load(1'b0, 8, 2, 0, 1'b0, -1, 1'b0);   // out of range
    run_load(1'b1, 3, 0, 0, 1'b0, -1, 1'b0);   // zero length
    run_load(1'b1, 2, 3, 40, 1'b0, -1, 1'b0);  // bubbles on in_valid
    run_load(1'b1, 1, 2, 0, 1'b1, -1, 1'b0);   // start while busy
    run_load(1'b1, 4, 2, 0, 1'b0, 7, 1'b0);    // reset after 7 words
    run_load(1'b0, 5, 1, 0, 1'b0, -1, 1'b0);   // fresh load after reset
    for (int i = 0; i < 4; i++) begin
      f = $urandom_range(NUM_BLOCKS - 1);
      c = $urandom_range(NUM_BLOCKS - f, 1);
      run_load(1'($urandom), f, c, (i % 2 == 0) ? 0 : 30, 1'b0, -1, 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("writes_outstanding", ROW_W'(wr_q.size()), ROW_W'(0));
    chk("dones_outstanding", ROW_W'(done_q.size()), ROW_W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1);
  end

endmodule
